// File: rtl/sdf_bf2_stage_4.sv
// Radix-2 DIF single-path delay-feedback butterfly stage (span 2*DEPTH).
// Sums leave directly; differences are fed back and leave twiddled one half-frame later.
module sdf_bf2_stage_4 #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4,
   parameter int FRAC  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] din_r,
   input  logic signed [WIDTH-1:0] din_i,
   input  logic        [1:0]       state,
   input  logic signed [WIDTH-1:0] w_r,
   input  logic signed [WIDTH-1:0] w_i,
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] dout_r,
   output logic signed [WIDTH-1:0] dout_i
);

   localparam int PW = 2*WIDTH + 1;

   typedef enum logic [1:0] {
      PH_FILL = 2'd0,
      PH_BFLY = 2'd1,
      PH_TWID = 2'd2,
      PH_RSVD = 2'd3
   } phase_t;

   phase_t phase;
   assign phase = phase_t'(state);

   logic                    adv;
   logic signed [WIDTH-1:0] b_r, b_i;
   logic signed [WIDTH-1:0] a_r, a_i;
   logic signed [WIDTH-1:0] dl_r [DEPTH];
   logic signed [WIDTH-1:0] dl_i [DEPTH];

   // Twiddle phases keep the line moving even without input so the last frame drains.
   assign adv = in_valid | (state != 2'd0);
   assign b_r = in_valid ? din_r : '0;
   assign b_i = in_valid ? din_i : '0;
   assign a_r = dl_r[DEPTH-1];
   assign a_i = dl_i[DEPTH-1];

   logic signed [WIDTH-1:0] sum_r, sum_i, dif_r, dif_i;
   assign sum_r = a_r + b_r;
   assign sum_i = a_i + b_i;
   assign dif_r = a_r - b_r;
   assign dif_i = a_i - b_i;

   logic signed [PW-1:0]    ax_r, ax_i, wx_r, wx_i;
   logic signed [PW-1:0]    prod_re, prod_im;
   logic signed [WIDTH-1:0] mul_r, mul_i;

   assign ax_r = {{(WIDTH+1){a_r[WIDTH-1]}}, a_r};
   assign ax_i = {{(WIDTH+1){a_i[WIDTH-1]}}, a_i};
   assign wx_r = {{(WIDTH+1){w_r[WIDTH-1]}}, w_r};
   assign wx_i = {{(WIDTH+1){w_i[WIDTH-1]}}, w_i};

   assign prod_re = ax_r*wx_r - ax_i*wx_i;
   assign prod_im = ax_r*wx_i + ax_i*wx_r;
   assign mul_r   = WIDTH'(prod_re >>> FRAC);
   assign mul_i   = WIDTH'(prod_im >>> FRAC);

   logic                    res_v;
   logic signed [WIDTH-1:0] res_r, res_i;
   logic signed [WIDTH-1:0] push_r, push_i;

   always_comb begin
      res_v  = 1'b0;
      res_r  = sum_r;
      res_i  = sum_i;
      push_r = b_r;
      push_i = b_i;
      case (phase)
         PH_BFLY: begin
            res_v  = 1'b1;
            push_r = dif_r;
            push_i = dif_i;
         end
         PH_TWID: begin
            res_v = 1'b1;
            res_r = mul_r;
            res_i = mul_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         dout_r    <= '0;
         dout_i    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            dl_r[i] <= '0;
            dl_i[i] <= '0;
         end
      end else begin
         out_valid <= adv & res_v;
         if (adv && res_v) begin
            dout_r <= res_r;
            dout_i <= res_i;
         end
         if (adv) begin
            dl_r[0] <= push_r;
            dl_i[0] <= push_i;
            for (int i = 1; i < DEPTH; i++) begin
               dl_r[i] <= dl_r[i-1];
               dl_i[i] <= dl_i[i-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_sdf_bf2_stage_4.sv
// Bench for sdf_bf2_stage_4: frame-level butterfly model, per-cycle expectation queue.
module tb_sdf_bf2_stage_4;
   localparam int W = 24;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] din_r = '0, din_i = '0, w_r = '0, w_i = '0;
   logic [1:0]   state = 2'd0;
   logic         out_valid;
   logic [W-1:0] dout_r, dout_i;

   always #5 clk = ~clk;

   sdf_bf2_stage_4 dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .din_r(din_r), .din_i(din_i), .state(state),
      .w_r(w_r), .w_i(w_i),
      .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i)
   );

   typedef struct {
      bit           v;
      logic [W-1:0] r;
      logic [W-1:0] i;
   } exp_t;

   exp_t         expq[$];
   exp_t         ce;
   int           n_checks = 0;
   int           n_fail = 0;
   logic [W-1:0] last_r = '0, last_i = '0;

   // frame storage: x[f][0..7], twiddles per difference index, model results
   logic [W-1:0] xr[8][8], xi[8][8];
   logic [W-1:0] twr[8][4], twi[8][4];
   logic [W-1:0] sr[8][4], si[8][4], tr[8][4], ti[8][4];

   task automatic chk(string name, logic [W-1:0] got, logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (expq.size() > 0) begin
         ce = expq.pop_front();
         chk("out_valid", W'(out_valid), W'(ce.v));
         chk("dout_r", dout_r, ce.r);
         chk("dout_i", dout_i, ce.i);
      end
   end

   function automatic logic [W-1:0] cm_re(logic [W-1:0] ar, logic [W-1:0] ai,
                                          logic [W-1:0] wr, logic [W-1:0] wi);
      longint a_r = $signed(ar), a_i = $signed(ai), v_r = $signed(wr), v_i = $signed(wi);
      longint p = a_r*v_r - a_i*v_i;
      p = p >>> 8;
      return p[W-1:0];
   endfunction

   function automatic logic [W-1:0] cm_im(logic [W-1:0] ar, logic [W-1:0] ai,
                                          logic [W-1:0] wr, logic [W-1:0] wi);
      longint a_r = $signed(ar), a_i = $signed(ai), v_r = $signed(wr), v_i = $signed(wi);
      longint p = a_r*v_i + a_i*v_r;
      p = p >>> 8;
      return p[W-1:0];
   endfunction

   // X[k] = x[k] + x[k+4];  Y[k] = (x[k] - x[k+4]) * W[k]
   task automatic model_frames(int nf);
      logic [W-1:0] d_r, d_i;
      for (int f = 0; f < nf; f++)
         for (int k = 0; k < 4; k++) begin
            sr[f][k] = xr[f][k] + xr[f][k+4];
            si[f][k] = xi[f][k] + xi[f][k+4];
            d_r = xr[f][k] - xr[f][k+4];
            d_i = xi[f][k] - xi[f][k+4];
            tr[f][k] = cm_re(d_r, d_i, twr[f][k], twi[f][k]);
            ti[f][k] = cm_im(d_r, d_i, twr[f][k], twi[f][k]);
         end
   endtask

   task automatic drive(bit rst, bit iv, logic [1:0] st, logic [W-1:0] dr, logic [W-1:0] di,
                        logic [W-1:0] wr, logic [W-1:0] wi, bit ev,
                        logic [W-1:0] er, logic [W-1:0] ei);
      exp_t e;
      @(negedge clk);
      rst_n = ~rst; in_valid = iv; state = st;
      din_r = dr; din_i = di; w_r = wr; w_i = wi;
      if (rst) begin
         last_r = '0; last_i = '0;
      end else if (ev) begin
         last_r = er; last_i = ei;
      end
      e.v = ev & ~rst; e.r = last_r; e.i = last_i;
      expq.push_back(e);
   endtask

   task automatic idle();
      drive(0, 0, 2'd0, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 0, '0, '0);
   endtask

   task automatic maybe_idle(int mode);
      if (mode == 2 && $urandom_range(0, 5) == 0)
         repeat ($urandom_range(1, 3)) idle();
   endtask

   task automatic clear_frames();
      for (int f = 0; f < 8; f++) begin
         for (int k = 0; k < 8; k++) begin
            xr[f][k] = '0; xi[f][k] = '0;
         end
         for (int k = 0; k < 4; k++) begin
            twr[f][k] = W'(256); twi[f][k] = '0;
         end
      end
   endtask

   task automatic std_tw(int f);
      twr[f][0] = W'(256);  twi[f][0] = W'(0);
      twr[f][1] = W'(181);  twi[f][1] = W'(-181);
      twr[f][2] = W'(0);    twi[f][2] = W'(-256);
      twr[f][3] = W'(-181); twi[f][3] = W'(-181);
   endtask

   task automatic rand_frames(int nf);
      int t;
      for (int f = 0; f < nf; f++) begin
         for (int k = 0; k < 8; k++) begin
            xr[f][k] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 2000) - 1000);
            xi[f][k] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 2000) - 1000);
         end
         for (int k = 0; k < 4; k++) begin
            t = int'($urandom_range(0, 512)) - 256; twr[f][k] = W'(t);
            t = int'($urandom_range(0, 512)) - 256; twi[f][k] = W'(t);
         end
      end
   endtask

   // idle_mode: 0 none, 1 three idles mid-fill, 2 random idles anywhere
   task automatic run_frames(int nf, bit with_fill, int idle_mode);
      if (!with_fill)
         for (int k = 0; k < 4; k++) begin
            xr[0][k] = '0; xi[0][k] = '0;
         end
      model_frames(nf);
      if (with_fill)
         for (int k = 0; k < 4; k++) begin
            if (idle_mode == 1 && k == 2) repeat (3) idle();
            maybe_idle(idle_mode);
            drive(0, 1, ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0, xr[0][k], xi[0][k],
                  W'($urandom), W'($urandom), 0, '0, '0);
         end
      for (int f = 0; f < nf; f++) begin
         for (int k = 0; k < 4; k++) begin
            maybe_idle(idle_mode);
            drive(0, 1, 2'd1, xr[f][k+4], xi[f][k+4], W'($urandom), W'($urandom),
                  1, sr[f][k], si[f][k]);
         end
         for (int k = 0; k < 4; k++) begin
            maybe_idle(idle_mode);
            if (f + 1 < nf)
               drive(0, 1, 2'd2, xr[f+1][k], xi[f+1][k], twr[f][k], twi[f][k],
                     1, tr[f][k], ti[f][k]);
            else
               drive(0, 0, 2'd2, W'($urandom), W'($urandom), twr[f][k], twi[f][k],
                     1, tr[f][k], ti[f][k]);
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_frames();
      repeat (3) drive(1, 1, 2'd1, W'(24'h00FFFF), W'(24'h00FFFF), '0, '0, 0, '0, '0);

      // impulse
      clear_frames(); xr[0][0] = W'(256); std_tw(0);
      run_frames(1, 1, 0);
      chk("pin_impulse_sum0", sr[0][0], W'(256));
      chk("pin_impulse_tw0", tr[0][0], W'(256));
      chk("pin_impulse_tw1", tr[0][1], W'(0));

      // twiddle rotation
      clear_frames(); xr[0][1] = W'(256); std_tw(0);
      run_frames(1, 1, 0);
      chk("pin_rot_sum1", sr[0][1], W'(256));
      chk("pin_rot_tw1_r", tr[0][1], W'(181));
      chk("pin_rot_tw1_i", ti[0][1], W'(-181));

      // back-to-back frames
      clear_frames(); std_tw(0); std_tw(1);
      for (int k = 0; k < 8; k++) begin
         xr[0][k] = W'(100); xr[1][k] = W'(k);
      end
      run_frames(2, 1, 0);
      chk("pin_b2b_A_sum", sr[0][2], W'(200));
      chk("pin_b2b_B_sum0", sr[1][0], W'(4));
      chk("pin_b2b_B_sum3", sr[1][3], W'(10));
      chk("pin_b2b_B_tw0", tr[1][0], W'(-4));
      chk("pin_b2b_B_tw1_r", tr[1][1], W'(-3));
      chk("pin_b2b_B_tw1_i", ti[1][1], W'(2));

      // wrap-around sum and difference
      clear_frames(); xr[0][0] = W'(24'h7FFFFF); xr[0][4] = W'(1);
      run_frames(1, 1, 0);
      chk("pin_wrap_sum", sr[0][0], W'(24'h800000));
      chk("pin_wrap_diff", tr[0][0], W'(24'h7FFFFE));

      // impulse again with an idle gap mid-fill
      clear_frames(); xr[0][0] = W'(256); std_tw(0);
      run_frames(1, 1, 1);

      for (int r = 0; r < 6; r++) begin
         int nf = $urandom_range(1, 3);
         clear_frames(); rand_frames(nf);
         run_frames(nf, 1, 2);
      end

      // reset mid-frame, then butterfly straight away reads a zeroed line
      clear_frames(); rand_frames(1); model_frames(1);
      for (int k = 0; k < 4; k++)
         drive(0, 1, 2'd0, xr[0][k], xi[0][k], '0, '0, 0, '0, '0);
      for (int k = 0; k < 2; k++)
         drive(0, 1, 2'd1, xr[0][k+4], xi[0][k+4], '0, '0, 1, sr[0][k], si[0][k]);
      repeat (2) drive(1, 1, 2'd1, W'($urandom), W'($urandom), '0, '0, 0, '0, '0);
      clear_frames(); rand_frames(1);
      run_frames(1, 0, 0);
      clear_frames(); rand_frames(2);
      run_frames(2, 1, 2);

      idle();
      repeat (3) @(negedge clk);
      chk("queue_drained", W'(expq.size()), W'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sdf_bf2_stage_4.md
# sdf_bf2_stage_4

Radix-2 decimation-in-frequency single-path delay-feedback (SDF) butterfly stage with a 4-deep feedback delay line. It is the datapath for the 8-point-span stage of the 512-point FFT pipeline. The stage consumes the twiddle generator's `state`, `w_r` and `w_i` outputs, performs the add/subtract butterfly, and multiplies the differences by the twiddle factors. Its output stream feeds the next (smaller-span) stage.

## Interface
Parameters:
- `WIDTH`, default 24: signed two's-complement width of data and twiddles.
- `DEPTH`, default 4: delay-line length (half the butterfly span).
- `FRAC`, default 8: twiddle fractional bits (1.0 = 256).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  input sample valid on `din_r`/`din_i`.
- `din_r`, `din_i`  in  WIDTH  signed input sample, real and imaginary parts.
- `state`  in  2  phase from the twiddle generator: 0 = fill, 1 = butterfly, 2 = twiddle, 3 = reserved.
- `w_r`, `w_i`  in  WIDTH  signed twiddle for the current cycle, Q(WIDTH-FRAC).FRAC.
- `out_valid`  out  1  output sample valid.
- `dout_r`, `dout_i`  out  WIDTH  signed output sample, registered.

## Operation
- **Advance.** `adv = in_valid | (state != 0)`. The delay line shifts by one entry only on cycles where `adv` = 1. When `in_valid` = 0 and `adv` = 1, `din` is treated as 0 (drain).
- **Delay line.** DEPTH entries of {re, im}. The head is the oldest entry and is read as `a`; `b = din`.
- **state 0 (fill).**
  - Push `b`.
  - No output: `out_valid` = 0 next cycle.
- **state 1 (butterfly).**
  - Output `a + b`.
  - Push `a - b`.
- **state 2 (twiddle).**
  - Output `a * W` (complex product).
  - Push `b`, which is the next frame's first half.
- **state 3.** Behaves exactly as state 0.
- **Add/subtract.** WIDTH-bit, wrap-around, no growth and no saturation.
- **Complex multiply.**
  - re = (a_r*w_r − a_i*w_i) >>> FRAC
  - im = (a_r*w_i + a_i*w_r) >>> FRAC
  - Products and the sum are computed at 2*WIDTH+1 bits.
  - The shift is arithmetic (truncation toward −inf); keep the low WIDTH bits.
- **Twiddle sampling.** `w_r`/`w_i` are sampled in the same cycle as `state` = 2. No internal twiddle storage.
- **Continuous frames.** The pattern fill×4, (butterfly×4, twiddle×4) repeats with no bubbles. The twiddle phase of frame n overlaps the fill of frame n+1.
- **Idle.** With `adv` = 0:
  - The delay line holds.
  - `out_valid` drops to 0.
  - `dout` holds its last value.

## Timing
- **Reset.** On a `clk` edge with `rst_n` = 0:
  - `out_valid` = 0, `dout_r` = 0, `dout_i` = 0.
  - All delay entries = 0.
  - Reset takes priority over `adv`.
  - A reset mid-frame discards partial data; the next frame starts from fill.
- **Latency.** An input or phase at edge t gives its result on `dout` after edge t+1 (one register stage). `out_valid` is set from (`adv` & `state` ∈ {1,2}) in that same cycle t.
- **Feedback delay.** A value pushed at advance k appears at the head at advance k + DEPTH, independent of idle gaps.
- **Throughput.** One sample per clock sustained. No backpressure.
- **Frame output order.** 4 sums (k = 0..3) followed by 4 twiddled differences (k = 0..3).

## Test plan
- **Reset.** Hold `rst_n` = 0 for 3 edges while driving `in_valid` = 1, `din` = 0x00FFFF, `state` = 1. Required: `out_valid` = 0 and `dout` = 0 throughout. After release, the first 4 fill samples produce no output.
- **Impulse.** Frame real = [256,0,0,0,0,0,0,0], imag all 0. States 0×4, 1×4, 2×4. Twiddles (256,0), (181,−181), (0,−256), (−181,−181). Required outputs in order: (256,0), (0,0)×3, then (256,0), (0,0)×3.
- **Twiddle rotation.** Frame real = [0,256,0,0,0,0,0,0]. Required:
  - Sums (0,0), (256,0), (0,0), (0,0).
  - Twiddled outputs (0,0), (181,−181), (0,0), (0,0).
- **Back-to-back frames.**
  - Frame A = constant (100,0); frame B = [0..7] real, sent with no gap.
  - Frame A: sums (200,0)×4, differences (0,0)×4.
  - Frame B: sums (4,0), (6,0), (8,0), (10,0).
  - Frame B difference k=0: (−4,0).
  - Frame B difference k=1: input (−4,0) × (181,−181) gives (−3,2), because −724>>>8 = −3 and 724>>>8 = 2.
- **Wrap and idle.**
  - a = (0x7FFFFF, 0) with b = (1, 0) in state 1. Required: sum = (0x800000, 0) and the pushed difference = (0x7FFFFE, 0).
  - Insert 3 idle cycles (`in_valid` = 0, `state` = 0) mid-fill. Required: identical outputs to the gapless run, and `out_valid` = 0 during the idle cycles.
